bmu_wb_queue: RTL and testbench

Result writeback queue directly downstream of the bit-manipulation unit (BMU). Tracks each BMU issue (`valid_in` plus its destination register tag) through the BMU's one-cycle result latency. Pairs the tag with `result_ff`/`error` when they appear and buffers the entry in a small FIFO. Drains the FIFO to the register-file writeback port over a valid/ready handshake, and raises a stall back to the issue logic so no BMU result is ever lost.

---
 rtl/bmu_wb_queue.sv | 124 ++++++++++++
 tb/tb_bmu_wb_queue.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmu_wb_queue.sv
// Writeback queue behind the BMU: pairs each issued tag with the registered result, buffers it and drains it to the RF port.
// Optional feature: define BMU_WB_BYPASS_EN to let a capture entry reach wb_* combinationally while the FIFO is empty.
module bmu_wb_queue #(
    parameter int DEPTH = 4,
    parameter int RD_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     valid_in,
    input  logic [RD_W-1:0]          rd_in,
    input  logic [31:0]              result_ff,
    input  logic                     error,
    input  logic                     flush,
    input  logic                     wb_ready,
    output logic                     wb_valid,
    output logic [RD_W-1:0]          wb_rd,
    output logic [31:0]              wb_data,
    output logic                     wb_error,
    output logic                     bmu_stall,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
        logic            err;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cap_v_q, cap_v_d;
    logic [RD_W-1:0] cap_rd_q, cap_rd_d;
    logic            overflow_q, overflow_d;

    entry_t cap_entry, out_entry;
    logic   fifo_empty, fifo_full, bypass_sel, bypass_take;
    logic   pop, push, push_ok, drop, mem_we;

    always_comb begin
        cap_entry  = '{rd: cap_rd_q, data: result_ff, err: error};
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CW'(DEPTH));
`ifdef BMU_WB_BYPASS_EN
        bypass_sel = fifo_empty & cap_v_q;
`else
        bypass_sel = 1'b0;
`endif
        // Outputs are forced to zero when nothing is presented so reset/idle values are clean.
        if (bypass_sel)
            out_entry = cap_entry;
        else if (!fifo_empty)
            out_entry = mem_q[rd_ptr_q];
        else
            out_entry = '0;

        pop         = ~fifo_empty & wb_ready;
        bypass_take = bypass_sel & wb_ready;
        push        = cap_v_q & ~bypass_take;
        push_ok     = push & (~fifo_full | pop);
        drop        = push & fifo_full & ~pop;
        mem_we      = push_ok & ~flush;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cap_v_d    = valid_in & ~flush;
        cap_rd_d   = rd_in;
        overflow_d = overflow_q | (drop & ~flush);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok)
                wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_ok && !pop)
                count_d = count_q + CW'(1);
            else if (!push_ok && pop)
                count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cap_v_q    <= 1'b0;
            cap_rd_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cap_v_q    <= cap_v_d;
            cap_rd_q   <= cap_rd_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: unread slots never reach the outputs.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[wr_ptr_q] <= cap_entry;
    end

    assign wb_valid  = ~fifo_empty | bypass_sel;
    assign wb_rd     = out_entry.rd;
    assign wb_data   = out_entry.data;
    assign wb_error  = out_entry.err;
    assign bmu_stall = ({1'b0, count_q} + (CW+1)'(cap_v_q)) >= (CW+1)'(DEPTH);
    assign overflow  = overflow_q;
    assign count     = count_q;

endmodule

// File: tb/tb_bmu_wb_queue.sv
// Self-checking bench for bmu_wb_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_bmu_wb_queue;

    localparam int DEPTH = 4;
    localparam int RD_W  = 5;
`ifdef BMU_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_l, valid_in, error, flush, wb_ready;
    logic [RD_W-1:0] rd_in;
    logic [31:0]     result_ff;
    logic            wb_valid, wb_error, bmu_stall, overflow;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;
    logic [2:0]      count;

    bmu_wb_queue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk(clk), .rst_l(rst_l), .valid_in(valid_in), .rd_in(rd_in),
        .result_ff(result_ff), .error(error), .flush(flush), .wb_ready(wb_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_error(wb_error),
        .bmu_stall(bmu_stall), .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
        logic            err;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    ent_t mq[$];
    bit   m_cap_v;
    logic [RD_W-1:0] m_cap_rd;
    bit   m_ovf;
    bit   e_valid, e_stall;
    ent_t e_ent;
    int   e_count;

    task automatic model_reset();
        mq.delete();
        m_cap_v  = 1'b0;
        m_cap_rd = '0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_out();
        e_count = mq.size();
        e_stall = (mq.size() + int'(m_cap_v)) >= DEPTH;
        if (mq.size() > 0) begin
            e_valid = 1'b1; e_ent = mq[0];
        end else if (BYP && m_cap_v) begin
            e_valid = 1'b1; e_ent = '{rd: m_cap_rd, data: result_ff, err: error};
        end else begin
            e_valid = 1'b0; e_ent = '0;
        end
    endtask

    task automatic model_edge();
        ent_t cap;
        bit   pop, was_full;
        model_out();
        cap = '{rd: m_cap_rd, data: result_ff, err: error};
        if (flush) begin
            mq.delete();
            m_cap_v = 1'b0;
        end else begin
            pop = e_valid && wb_ready;
            if (BYP && mq.size() == 0 && m_cap_v) begin
                if (!wb_ready) mq.push_back(cap);
            end else begin
                was_full = (mq.size() == DEPTH);
                if (pop) void'(mq.pop_front());
                if (m_cap_v) begin
                    if (was_full && !pop) m_ovf = 1'b1;
                    else mq.push_back(cap);
                end
            end
            m_cap_v  = valid_in;
            m_cap_rd = rd_in;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        result_ff = $urandom;
        error     = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0; valid_in = 0; rd_in = '0; result_ff = '0; error = 0; flush = 0; wb_ready = 0;
        model_reset();
        #2;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if ({wb_rd, wb_data, wb_error} !== '0) begin errors++; $display("FAIL reset_wb_fields got=%h/%h/%b exp=0", wb_rd, wb_data, wb_error); end
        checks++; if ({bmu_stall, overflow} !== 2'b00) begin errors++; $display("FAIL reset_stall_ovf got=%b%b exp=00", bmu_stall, overflow); end
        #5 rst_l = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        wb_ready = 1; valid_in = 1; rd_in = 5'd5;
        tick();
        valid_in = 0; result_ff = 32'h0000_00FF; error = 0; #1;
        checks++; if (wb_valid !== BYP) begin errors++; $display("FAIL single_n1_valid got=%0b exp=%0b", wb_valid, BYP); end
        if (BYP) begin
            checks++; if (wb_rd !== 5'd5 || wb_data !== 32'hFF) begin errors++; $display("FAIL single_n1_bypass got=%0d/%h exp=5/ff", wb_rd, wb_data); end
        end
        tick();
        if (!BYP) begin
            checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'hFF || wb_error !== 1'b0)
                begin errors++; $display("FAIL single_n2_head got=%0b/%0d/%h/%0b exp=1/5/ff/0", wb_valid, wb_rd, wb_data, wb_error); end
        end
        tick();
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) begin errors++; $display("FAIL single_drained got=%0d/%0b exp=0/0", count, wb_valid); end
    endtask

    task automatic test_fill_overflow_wrap();
        int got[$];
        wb_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            valid_in = 1; rd_in = RD_W'(i);
            tick();
        end
        valid_in = 0; #1;
        checks++; if (bmu_stall !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL fill_stall got=%0b/%0d exp=1/3", bmu_stall, count); end
        tick();
        checks++; if (count !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL fill_full got=%0d/%0b exp=4/0", count, overflow); end
        valid_in = 1; rd_in = 5'd9;
        tick();
        valid_in = 0;
        tick();
        checks++; if (overflow !== 1'b1 || count !== 3'd4 || wb_rd !== 5'd1)
            begin errors++; $display("FAIL overflow_drop got=%0b/%0d/%0d exp=1/4/1", overflow, count, wb_rd); end
        valid_in = 1; rd_in = 5'd5;
        tick();
        wb_ready = 1;
        for (int i = 6; i <= 9; i++) begin
            if (i <= 8) begin valid_in = 1; rd_in = RD_W'(i); end else valid_in = 0;
            #1;
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL pushpop_full_count got=%0d exp=4", count); end
            if (wb_valid) got.push_back(int'(wb_rd));
            tick();
        end
        valid_in = 0;
        for (int c = 0; c < 20 && (got.size() < 8 || wb_valid); c++) begin
            if (wb_valid) got.push_back(int'(wb_rd));
            tick();
        end
        checks++; if (got.size() != 8) begin errors++; $display("FAIL wrap_order_len got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] != i + 1) begin errors++; $display("FAIL wrap_order idx=%0d got=%0d exp=%0d", i, got[i], i + 1); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_flush();
        wb_ready = 0;
        for (int i = 10; i <= 12; i++) begin
            valid_in = 1; rd_in = RD_W'(i);
            tick();
        end
        valid_in = 0; flush = 1; #1;
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
        tick();
        flush = 0; #1;
        checks++; if (count !== 3'd0 || wb_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got=%0d/%0b exp=0/0", count, wb_valid); end
        wb_ready = 1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost got_rd=%0d exp=no_valid", wb_rd); end
            tick();
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf got=%0b exp=1", overflow); end
    endtask

    task automatic test_async_reset();
        wb_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            valid_in = 1; rd_in = RD_W'(i + 20);
            tick();
        end
        valid_in = 0; #1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
        rst_l = 0; #1;
        checks++; if ({wb_valid, wb_rd, wb_data, wb_error, bmu_stall, overflow, count} !== '0)
            begin errors++; $display("FAIL areset_outputs got=%0b/%0d/%h/%0b/%0b/%0b/%0d exp=all0", wb_valid, wb_rd, wb_data, wb_error, bmu_stall, overflow, count); end
        model_reset();
        #1 rst_l = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            model_out();
            flush    = ($urandom_range(0, 99) < 4);
            wb_ready = ($urandom_range(0, 99) < 55);
            valid_in = ($urandom_range(0, 99) < 65) && (!e_stall || $urandom_range(0, 19) == 0);
            rd_in    = RD_W'($urandom);
            error    = $urandom_range(0, 1);
            #1;
            model_out();
            checks++; if (wb_valid !== e_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", c, wb_valid, e_valid); end
            checks++; if (int'(count) != e_count) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", c, count, e_count); end
            checks++; if (bmu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", c, bmu_stall, e_stall); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%0b exp=%0b", c, overflow, m_ovf); end
            if (e_valid) begin
                checks++; if ({wb_rd, wb_data, wb_error} !== e_ent)
                    begin errors++; $display("FAIL rnd_head cyc=%0d got=%0d/%h/%0b exp=%0d/%h/%0b", c, wb_rd, wb_data, wb_error, e_ent.rd, e_ent.data, e_ent.err); end
            end
            tick();
        end
        flush = 0; valid_in = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
